// File: rtl/mc_result_scheduler.sv
// Issue gating, int/FP pending-destination scoreboards, per-unit result holding
// registers and round-robin writeback for the shared multicycle EXE result slot.
module mc_result_scheduler #(
    parameter int N_UNITS = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    issue_valid,
    input  logic [1:0]              issue_unit,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_fp,
    output logic                    issue_ready,
    output logic [N_UNITS-1:0]      unit_start,
    input  logic [N_UNITS-1:0]      unit_done,
    input  logic [N_UNITS*XLEN-1:0] unit_result,
    input  logic [4:0]              rs1_id,
    input  logic [4:0]              rs2_id,
    input  logic [4:0]              rs3_id,
    input  logic                    rs1_fp,
    input  logic                    rs2_fp,
    input  logic                    rs3_fp,
    output logic                    rd_busy,
    output logic [N_UNITS-1:0]      unit_busy,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [1:0]              wb_unit,
    output logic [4:0]              wb_rd,
    output logic                    wb_fp,
    output logic [XLEN-1:0]         wb_data,
    output logic                    protocol_err
);

    logic [N_UNITS-1:0] unit_busy_q, unit_busy_d;
    logic [N_UNITS-1:0] hold_v_q, hold_v_d;
    logic [XLEN-1:0]    hold_data_q [N_UNITS];
    logic [XLEN-1:0]    hold_data_d [N_UNITS];
    logic [4:0]         tag_rd_q [N_UNITS];
    logic [4:0]         tag_rd_d [N_UNITS];
    logic [N_UNITS-1:0] tag_fp_q, tag_fp_d;
    logic [31:0]        sb_int_q, sb_int_d;
    logic [31:0]        sb_fp_q, sb_fp_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               protocol_err_q, protocol_err_d;

    logic               unit_idle_s;
    logic               grant_v_s;
    logic               grant_hit_s;
    logic [1:0]         grant_idx_s;
    logic               wb_fire_s;
    logic [N_UNITS-1:0] done_ok_s;
    logic [N_UNITS-1:0] wb_clear_s;
    logic [31:0]        sb_int_set_s, sb_fp_set_s, sb_int_clr_s, sb_fp_clr_s;

    // Int x0 is hardwired zero and never counts as pending.
    function automatic logic sb_lookup(input logic [31:0] sb_int, input logic [31:0] sb_fp,
                                       input logic [4:0] rd, input logic fp);
        logic hit;
        if (fp) begin
            hit = sb_fp[rd];
        end else begin
            hit = sb_int[rd] & (rd != 5'd0);
        end
        return hit;
    endfunction

    // Issue acceptance; an out-of-range unit index matches no unit and is never accepted.
    always_comb begin
        unit_idle_s = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            unit_idle_s = unit_idle_s | ((issue_unit == 2'(i)) & ~unit_busy_q[i]);
        end
        issue_ready = issue_valid & unit_idle_s
                      & ~sb_lookup(sb_int_q, sb_fp_q, issue_rd, issue_fp);
        for (int i = 0; i < N_UNITS; i++) begin
            unit_start[i] = issue_ready & (issue_unit == 2'(i));
        end
        rd_busy = sb_lookup(sb_int_q, sb_fp_q, rs1_id, rs1_fp)
                | sb_lookup(sb_int_q, sb_fp_q, rs2_id, rs2_fp)
                | sb_lookup(sb_int_q, sb_fp_q, rs3_id, rs3_fp);
    end

    // Round-robin grant: first held result after rr_ptr, then the writeback mux.
    always_comb begin
        grant_v_s   = 1'b0;
        grant_hit_s = 1'b0;
        grant_idx_s = 2'd0;
        for (int k = 1; k <= N_UNITS; k++) begin
            for (int i = 0; i < N_UNITS; i++) begin
                grant_hit_s = hold_v_q[i] & ~grant_v_s
                              & (((int'(rr_ptr_q) + k) % N_UNITS) == i);
                grant_idx_s = grant_hit_s ? 2'(i) : grant_idx_s;
                grant_v_s   = grant_v_s | grant_hit_s;
            end
        end
        wb_valid = grant_v_s;
        wb_unit  = grant_idx_s;
        wb_rd    = 5'd0;
        wb_fp    = 1'b0;
        wb_data  = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            wb_rd   = wb_rd   | ((grant_v_s && grant_idx_s == 2'(i)) ? tag_rd_q[i] : 5'd0);
            wb_fp   = wb_fp   | (grant_v_s && grant_idx_s == 2'(i) && tag_fp_q[i]);
            wb_data = wb_data | ((grant_v_s && grant_idx_s == 2'(i)) ? hold_data_q[i] : '0);
        end
    end

    // Next state: completion capture, issue bookkeeping and writeback release.
    always_comb begin
        wb_fire_s    = grant_v_s & wb_ready;
        done_ok_s    = unit_done & unit_busy_q & ~hold_v_q;
        sb_int_set_s = {31'd0, issue_ready & ~issue_fp & (issue_rd != 5'd0)} << issue_rd;
        sb_fp_set_s  = {31'd0, issue_ready & issue_fp} << issue_rd;
        sb_int_clr_s = {31'd0, wb_fire_s & ~wb_fp} << wb_rd;
        sb_fp_clr_s  = {31'd0, wb_fire_s & wb_fp} << wb_rd;
        for (int i = 0; i < N_UNITS; i++) begin
            wb_clear_s[i]  = wb_fire_s & (grant_idx_s == 2'(i));
            unit_busy_d[i] = unit_start[i] | (unit_busy_q[i] & ~wb_clear_s[i]);
            hold_v_d[i]    = done_ok_s[i] | (hold_v_q[i] & ~wb_clear_s[i]);
            hold_data_d[i] = done_ok_s[i] ? unit_result[i*XLEN +: XLEN] : hold_data_q[i];
            tag_rd_d[i]    = unit_start[i] ? issue_rd : tag_rd_q[i];
            tag_fp_d[i]    = unit_start[i] ? issue_fp : tag_fp_q[i];
        end
        sb_int_d       = (sb_int_q & ~sb_int_clr_s) | sb_int_set_s;
        sb_fp_d        = (sb_fp_q & ~sb_fp_clr_s) | sb_fp_set_s;
        rr_ptr_d       = wb_fire_s ? grant_idx_s : rr_ptr_q;
        protocol_err_d = protocol_err_q | (|(unit_done & ~done_ok_s));
    end

    // State registers with synchronous active-low reset that discards in-flight work.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            unit_busy_q    <= '0;
            hold_v_q       <= '0;
            tag_fp_q       <= '0;
            sb_int_q       <= 32'd0;
            sb_fp_q        <= 32'd0;
            rr_ptr_q       <= 2'd0;
            protocol_err_q <= 1'b0;
            for (int i = 0; i < N_UNITS; i++) begin
                hold_data_q[i] <= '0;
                tag_rd_q[i]    <= 5'd0;
            end
        end else begin
            unit_busy_q    <= unit_busy_d;
            hold_v_q       <= hold_v_d;
            tag_fp_q       <= tag_fp_d;
            sb_int_q       <= sb_int_d;
            sb_fp_q        <= sb_fp_d;
            rr_ptr_q       <= rr_ptr_d;
            protocol_err_q <= protocol_err_d;
            for (int i = 0; i < N_UNITS; i++) begin
                hold_data_q[i] <= hold_data_d[i];
                tag_rd_q[i]    <= tag_rd_d[i];
            end
        end
    end

    assign unit_busy    = unit_busy_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mc_result_scheduler.sv
// Table-driven per-cycle bench for mc_result_scheduler plus a hand-written reset sequence.
module tb_mc_result_scheduler;

    localparam int N = 3;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid;
    logic [1:0]    issue_unit;
    logic [4:0]    issue_rd;
    logic          issue_fp;
    logic          issue_ready;
    logic [N-1:0]  unit_start;
    logic [N-1:0]  unit_done;
    logic [N*XL-1:0] unit_result;
    logic [4:0]    rs1_id, rs2_id, rs3_id;
    logic          rs1_fp, rs2_fp, rs3_fp;
    logic          rd_busy;
    logic [N-1:0]  unit_busy;
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    wb_unit;
    logic [4:0]    wb_rd;
    logic          wb_fp;
    logic [XL-1:0] wb_data;
    logic          protocol_err;

    int n_checks = 0;
    int n_errors = 0;
    int cur_row  = 0;

    mc_result_scheduler #(.N_UNITS(N), .XLEN(XL)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rd(issue_rd),
        .issue_fp(issue_fp), .issue_ready(issue_ready), .unit_start(unit_start),
        .unit_done(unit_done), .unit_result(unit_result),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs3_id(rs3_id),
        .rs1_fp(rs1_fp), .rs2_fp(rs2_fp), .rs3_fp(rs3_fp),
        .rd_busy(rd_busy), .unit_busy(unit_busy),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_unit(wb_unit),
        .wb_rd(wb_rd), .wb_fp(wb_fp), .wb_data(wb_data), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  iu;
        logic [4:0]  ird;
        logic        ifp;
        logic [2:0]  done;
        logic [31:0] res;
        logic        wbr;
        logic [4:0]  rs1;
        logic        rs1fp;
        int          reps;
        logic        e_ir;
        logic [2:0]  e_start;
        logic        e_rdb;
        logic        e_wbv;
        logic [1:0]  e_wbu;
        logic [4:0]  e_wbrd;
        logic        e_wbfp;
        logic [31:0] e_data;
        logic [2:0]  e_ubusy;
        logic        e_perr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [1:0] iu, input logic [4:0] ird, input logic ifp,
                       input logic [2:0] done, input logic [31:0] res, input logic wbr,
                       input logic [4:0] rs1, input logic rs1fp, input int reps,
                       input logic e_ir, input logic [2:0] e_start, input logic e_rdb,
                       input logic e_wbv, input logic [1:0] e_wbu, input logic [4:0] e_wbrd,
                       input logic e_wbfp, input logic [31:0] e_data, input logic [2:0] e_ubusy,
                       input logic e_perr);
        vec_t v;
        v.iv = iv; v.iu = iu; v.ird = ird; v.ifp = ifp; v.done = done; v.res = res;
        v.wbr = wbr; v.rs1 = rs1; v.rs1fp = rs1fp; v.reps = reps;
        v.e_ir = e_ir; v.e_start = e_start; v.e_rdb = e_rdb; v.e_wbv = e_wbv;
        v.e_wbu = e_wbu; v.e_wbrd = e_wbrd; v.e_wbfp = e_wbfp; v.e_data = e_data;
        v.e_ubusy = e_ubusy; v.e_perr = e_perr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, cur_row, act, exp);
        end
    endtask

    // Unit i sees result res + i so the granted unit is visible in wb_data.
    task automatic drive_result(input logic [31:0] res);
        for (int i = 0; i < N; i++) begin
            unit_result[i*XL +: XL] = res + 32'(i);
        end
    endtask

    initial begin
        reset_n = 1'b0; issue_valid = 1'b0; issue_unit = 2'd0; issue_rd = 5'd0; issue_fp = 1'b0;
        unit_done = 3'b000; unit_result = '0; wb_ready = 1'b0;
        rs1_id = 5'd0; rs2_id = 5'd0; rs3_id = 5'd0; rs1_fp = 1'b0; rs2_fp = 1'b0; rs3_fp = 1'b0;

        // A: div rd=x7, done 10 cycles after issue, immediate writeback
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd7,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        add(1'b1,2'd0,5'd7,1'b0,3'b000,32'h0,1'b1,5'd7,1'b0,1, 1'b1,3'b001,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd7,1'b0,9, 1'b0,3'b000,1'b1,1'b0,2'd0,5'd0,1'b0,32'h0,3'b001,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b001,32'h1234_5678,1'b1,5'd7,1'b0,1, 1'b0,3'b000,1'b1,1'b0,2'd0,5'd0,1'b0,32'h0,3'b001,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd7,1'b0,1, 1'b0,3'b000,1'b1,1'b1,2'd0,5'd7,1'b0,32'h1234_5678,3'b001,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd7,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        // B: fdiv f3 + fsqrt f4 done together, div x12 one cycle later, 3 stall cycles
        add(1'b1,2'd1,5'd3,1'b1,3'b000,32'h0,1'b0,5'd0,1'b0,1, 1'b1,3'b010,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        add(1'b1,2'd2,5'd4,1'b1,3'b000,32'h0,1'b0,5'd0,1'b0,1, 1'b1,3'b100,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b010,1'b0);
        add(1'b1,2'd0,5'd12,1'b0,3'b000,32'h0,1'b0,5'd0,1'b0,1, 1'b1,3'b001,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b110,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b110,32'hB000_0000,1'b0,5'd4,1'b1,1, 1'b0,3'b000,1'b1,1'b0,2'd0,5'd0,1'b0,32'h0,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b001,32'hC000_0000,1'b0,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b1,2'd1,5'd3,1'b1,32'hB000_0001,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b0,5'd0,1'b0,2, 1'b0,3'b000,1'b0,1'b1,2'd1,5'd3,1'b1,32'hB000_0001,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd3,1'b1,1, 1'b0,3'b000,1'b1,1'b1,2'd1,5'd3,1'b1,32'hB000_0001,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd3,1'b1,1, 1'b0,3'b000,1'b0,1'b1,2'd2,5'd4,1'b1,32'hB000_0002,3'b101,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b1,2'd0,5'd12,1'b0,32'hC000_0000,3'b001,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        // C: WAW blocking, busy unit, fp/int independence, x0 destination, bad unit index
        add(1'b1,2'd0,5'd9,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b1,3'b001,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        add(1'b1,2'd2,5'd9,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b001,1'b0);
        add(1'b1,2'd0,5'd5,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b001,1'b0);
        add(1'b1,2'd2,5'd9,1'b1,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b1,3'b100,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b001,1'b0);
        add(1'b1,2'd1,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b1,3'b010,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b101,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd9,1'b0,1, 1'b0,3'b000,1'b1,1'b0,2'd0,5'd0,1'b0,32'h0,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b111,32'hD000_0000,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b1,2'd1,5'd0,1'b0,32'hD000_0001,3'b111,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b1,2'd2,5'd9,1'b1,32'hD000_0002,3'b101,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b1,2'd0,5'd9,1'b0,32'hD000_0000,3'b001,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd9,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        add(1'b1,2'd3,5'd1,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        // D: spurious done from idle fdiv, sticky protocol error
        add(1'b0,2'd0,5'd0,1'b0,3'b010,32'hDEAD_0000,1'b1,5'd0,1'b0,1, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b0);
        add(1'b0,2'd0,5'd0,1'b0,3'b000,32'h0,1'b1,5'd0,1'b0,3, 1'b0,3'b000,1'b0,1'b0,2'd0,5'd0,1'b0,32'h0,3'b000,1'b1);

        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                @(negedge clk);
                cur_row = r;
                issue_valid = tbl[r].iv; issue_unit = tbl[r].iu; issue_rd = tbl[r].ird;
                issue_fp = tbl[r].ifp; unit_done = tbl[r].done; drive_result(tbl[r].res);
                wb_ready = tbl[r].wbr; rs1_id = tbl[r].rs1; rs1_fp = tbl[r].rs1fp;
                #1;
                chk("issue_ready", 32'(issue_ready), 32'(tbl[r].e_ir));
                chk("unit_start", 32'(unit_start), 32'(tbl[r].e_start));
                chk("rd_busy", 32'(rd_busy), 32'(tbl[r].e_rdb));
                chk("wb_valid", 32'(wb_valid), 32'(tbl[r].e_wbv));
                chk("unit_busy", 32'(unit_busy), 32'(tbl[r].e_ubusy));
                chk("protocol_err", 32'(protocol_err), 32'(tbl[r].e_perr));
                if (tbl[r].e_wbv) begin
                    chk("wb_unit", 32'(wb_unit), 32'(tbl[r].e_wbu));
                    chk("wb_rd", 32'(wb_rd), 32'(tbl[r].e_wbrd));
                    chk("wb_fp", 32'(wb_fp), 32'(tbl[r].e_wbfp));
                    chk("wb_data", wb_data, tbl[r].e_data);
                end
            end
        end

        // E: reset while div is busy with its result held; stale done afterwards
        cur_row = 100;
        @(negedge clk);
        issue_valid = 1'b1; issue_unit = 2'd0; issue_rd = 5'd7; issue_fp = 1'b0;
        unit_done = 3'b000; wb_ready = 1'b0; rs1_id = 5'd0;
        #1 chk("e_issue_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0; unit_done = 3'b001; drive_result(32'hE000_0000);
        @(negedge clk);
        unit_done = 3'b000; rs3_id = 5'd7;
        #1;
        chk("e_held_wb_valid", 32'(wb_valid), 32'd1);
        chk("e_held_wb_data", wb_data, 32'hE000_0000);
        chk("e_rs3_rd_busy", 32'(rd_busy), 32'd1);
        chk("e_perr_before", 32'(protocol_err), 32'd1);
        @(negedge clk);
        reset_n = 1'b0; rs3_id = 5'd0;
        @(negedge clk);
        reset_n = 1'b1; rs1_id = 5'd7;
        #1;
        chk("e_rst_unit_busy", 32'(unit_busy), 32'd0);
        chk("e_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("e_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("e_rst_wb_data", wb_data, 32'd0);
        chk("e_rst_rd_busy", 32'(rd_busy), 32'd0);
        chk("e_rst_perr", 32'(protocol_err), 32'd0);
        chk("e_rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("e_rst_unit_start", 32'(unit_start), 32'd0);
        @(negedge clk);
        unit_done = 3'b001;
        #1 chk("e_stale_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        unit_done = 3'b000;
        #1;
        chk("e_stale_perr", 32'(protocol_err), 32'd1);
        chk("e_stale_wb_valid2", 32'(wb_valid), 32'd0);
        chk("e_stale_unit_busy", 32'(unit_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
